// File: rtl/svi_chan_pkg.sv
// Shared types, reset constants and helpers for the channel-array block.
// Channel cells and the array top import this package.
package svi_chan_pkg;

    localparam int WIDTH = 8;

    typedef enum logic [1:0] {
        RESET,
        INIT,
        RUN,
        PAUSE
    } state_e;

    typedef struct packed {
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        logic [WIDTH-1:0] z;
    } chan_regs_t;

    // Held at 32 bits so cells of any width up to 32 can slice them down.
    localparam logic [31:0] X_RST = 32'd0;
    localparam logic [31:0] Y_RST = 32'd1;
    localparam logic [31:0] Z_RST = 32'd0;

    // Rotate the low w bits of v left by one; bits at and above w stay zero.
    function automatic logic [31:0] rotl1(input logic [31:0] v, input int w);
        logic [31:0] mask;
        mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        return ((v << 1) | (v >> (w - 1))) & mask;
    endfunction

endpackage

// File: rtl/svi_chan_cell.sv
// One channel: x up/down counter, y rotated on each wrap, z saturating wrap count.
// A load takes priority over a step issued in the same cycle.
module svi_chan_cell
    import svi_chan_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init,
    input  logic             step,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] ld_val,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] z
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] x_nxt;
    logic [WIDTH-1:0] y_rot;
    logic [31:0]      rot_full;
    logic             wrap;
    logic             z_max;

    assign x_nxt    = dir ? (x - ONE) : (x + ONE);
    assign wrap     = dir ? (x == '0) : (x == '1);
    assign rot_full = rotl1(32'(y), WIDTH);
    assign y_rot    = rot_full[WIDTH-1:0];
    assign z_max    = &z;

    always_ff @(posedge clk or posedge rst) begin
        if (rst || init) begin
            x <= X_RST[WIDTH-1:0];
            y <= Y_RST[WIDTH-1:0];
            z <= Z_RST[WIDTH-1:0];
        end else if (load) begin
            x <= ld_val;
            z <= '0;
        end else if (step) begin
            x <= x_nxt;
            if (wrap) begin
                y <= y_rot;
                if (!z_max) z <= z + ONE;
            end
        end
    end

endmodule

// File: rtl/svi_chan_array.sv
// Bank of NUM_CH channel cells behind a shared load port, gated by a small
// RESET/INIT/RUN/PAUSE controller.
module svi_chan_array
    import svi_chan_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int WIDTH  = 8,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_halt,
    input  logic [NUM_CH-1:0]       i_en,
    input  logic [NUM_CH-1:0]       i_dir,
    input  logic                    i_ld_vld,
    input  logic [CH_W-1:0]         i_ld_ch,
    input  logic [WIDTH-1:0]        i_ld_val,
    output logic                    o_ld_rdy,
    output logic                    o_ld_err,
    output logic [NUM_CH*WIDTH-1:0] o_a,
    output logic [NUM_CH*WIDTH-1:0] o_b,
    output logic [NUM_CH*WIDTH-1:0] o_c
);

    state_e state;
    state_e state_nxt;
    logic   ld_acc;
    logic   ld_bad;
    logic   in_init;
    logic   in_run;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= RESET;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RESET:   state_nxt = INIT;
            INIT:    state_nxt = RUN;
            RUN:     if (i_halt)  state_nxt = PAUSE;
            PAUSE:   if (!i_halt) state_nxt = RUN;
            default: state_nxt = RESET;
        endcase
    end

    assign in_init = (state == INIT);
    assign in_run  = (state == RUN);
    assign ld_acc  = i_ld_vld && o_ld_rdy;
    assign ld_bad  = int'(i_ld_ch) >= NUM_CH;

    // Ready is registered from the next state so it rises together with RUN.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_ld_rdy <= 1'b0;
            o_ld_err <= 1'b0;
        end else begin
            o_ld_rdy <= (state_nxt == RUN) || (state_nxt == PAUSE);
            o_ld_err <= ld_acc && ld_bad;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        svi_chan_cell #(
            .WIDTH(WIDTH)
        ) u_cell (
            .clk   (i_clk),
            .rst   (i_rst),
            .init  (in_init),
            .step  (in_run && i_en[k]),
            .dir   (i_dir[k]),
            .load  (ld_acc && (i_ld_ch == CH_W'(k))),
            .ld_val(i_ld_val),
            .x     (o_a[k*WIDTH +: WIDTH]),
            .y     (o_b[k*WIDTH +: WIDTH]),
            .z     (o_c[k*WIDTH +: WIDTH])
        );
    end

endmodule

// File: tb/tb_svi_chan_array.sv
// Randomised scoreboard bench for svi_chan_array with NUM_CH=3, WIDTH=8.
// The driver predicts each edge with an arithmetic model; a monitor pops and compares.
module tb_svi_chan_array;

    logic        clk = 1'b0;
    logic        rst;
    logic        halt;
    logic [2:0]  en;
    logic [2:0]  dir;
    logic        ld_vld;
    logic [1:0]  ld_ch;
    logic [7:0]  ld_val;
    logic        ld_rdy;
    logic        ld_err;
    logic [23:0] a;
    logic [23:0] b;
    logic [23:0] c;

    always #5 clk = ~clk;

    svi_chan_array #(.NUM_CH(3), .WIDTH(8)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_halt  (halt),
        .i_en    (en),
        .i_dir   (dir),
        .i_ld_vld(ld_vld),
        .i_ld_ch (ld_ch),
        .i_ld_val(ld_val),
        .o_ld_rdy(ld_rdy),
        .o_ld_err(ld_err),
        .o_a     (a),
        .o_b     (b),
        .o_c     (c)
    );

    typedef struct {
        logic        rdy;
        logic        err;
        logic [23:0] a;
        logic [23:0] b;
        logic [23:0] c;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_fail = 0;

    // Reference state: plain integers, one entry per channel.
    int   mx[3];
    int   my[3];
    int   mz[3];
    int   edges;
    bit   paused;
    logic rdy_m;
    logic err_m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " a"}, 32'(a), 32'h0);
        chk({tag, " b"}, 32'(b), 32'h010101);
        chk({tag, " c"}, 32'(c), 32'h0);
        chk({tag, " ld_rdy"}, 32'(ld_rdy), 32'h0);
        chk({tag, " ld_err"}, 32'(ld_err), 32'h0);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            mx[k] = 0;
            my[k] = 1;
            mz[k] = 0;
        end
        edges  = 0;
        paused = 1'b0;
        rdy_m  = 1'b0;
        err_m  = 1'b0;
    endtask

    task automatic model_edge(input logic h, input logic [2:0] e, input logic [2:0] d,
                              input logic v, input logic [1:0] ch, input logic [7:0] val);
        bit wrap;
        if (edges < 2) begin
            // First edge enters INIT, second enters RUN; state is reset-valued throughout.
            for (int k = 0; k < 3; k++) begin
                mx[k] = 0;
                my[k] = 1;
                mz[k] = 0;
            end
            rdy_m  = (edges == 1);
            err_m  = 1'b0;
            paused = 1'b0;
            edges++;
        end else begin
            err_m = v && (int'(ch) >= 3);
            for (int k = 0; k < 3; k++) begin
                if (v && int'(ch) == k) begin
                    mx[k] = int'(val);
                    mz[k] = 0;
                end else if (!paused && e[k]) begin
                    wrap  = d[k] ? (mx[k] == 0) : (mx[k] == 255);
                    mx[k] = d[k] ? (mx[k] + 255) % 256 : (mx[k] + 1) % 256;
                    if (wrap) begin
                        my[k] = ((my[k] * 2) % 256) + (my[k] / 128);
                        mz[k] = (mz[k] == 255) ? 255 : mz[k] + 1;
                    end
                end
            end
            paused = h;
            rdy_m  = 1'b1;
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.rdy = rdy_m;
        e.err = err_m;
        e.a   = '0;
        e.b   = '0;
        e.c   = '0;
        for (int k = 0; k < 3; k++) begin
            e.a[k*8 +: 8] = 8'(mx[k]);
            e.b[k*8 +: 8] = 8'(my[k]);
            e.c[k*8 +: 8] = 8'(mz[k]);
        end
        q.push_back(e);
    endtask

    // Called at a negedge: apply inputs, predict the next edge, then wait out that edge.
    task automatic drive(input logic h, input logic [2:0] e, input logic [2:0] d,
                         input logic v, input logic [1:0] ch, input logic [7:0] val);
        halt   = h;
        en     = e;
        dir    = d;
        ld_vld = v;
        ld_ch  = ch;
        ld_val = val;
        model_edge(h, e, d, v, ch, val);
        push_exp();
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() != 0) begin
            mon_e = q.pop_front();
            chk("ld_rdy", 32'(ld_rdy), 32'(mon_e.rdy));
            chk("ld_err", 32'(ld_err), 32'(mon_e.err));
            chk("o_a", 32'(a), 32'(mon_e.a));
            chk("o_b", 32'(b), 32'(mon_e.b));
            chk("o_c", 32'(c), 32'(mon_e.c));
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst    = 1'b1;
        halt   = 1'b0;
        en     = '0;
        dir    = '0;
        ld_vld = 1'b0;
        ld_ch  = '0;
        ld_val = '0;
        #2;
        chk_reset("por");
        repeat (2) @(posedge clk);
        #1;
        chk_reset("held");
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Release: ready low for two edges, then high.
        repeat (3) drive(1'b0, 3'b000, 3'b000, 1'b0, 2'd0, 8'h00);

        // Load ch1 with 0xFE and count up through the wrap.
        drive(1'b0, 3'b000, 3'b000, 1'b1, 2'd1, 8'hFE);
        repeat (3) drive(1'b0, 3'b010, 3'b000, 1'b0, 2'd0, 8'h00);

        // Ch0 down from 0, then 256 further wraps to reach z saturation.
        repeat (1 + 256 * 256) drive(1'b0, 3'b001, 3'b001, 1'b0, 2'd0, 8'h00);

        // Load beats step on the same channel; out-of-range load only pulses the error.
        drive(1'b0, 3'b100, 3'b000, 1'b1, 2'd2, 8'h10);
        drive(1'b0, 3'b000, 3'b000, 1'b1, 2'd3, 8'h55);
        repeat (2) drive(1'b0, 3'b000, 3'b000, 1'b0, 2'd0, 8'h00);

        // Halt during counting, load while paused, then resume.
        repeat (3) drive(1'b0, 3'b111, 3'b000, 1'b0, 2'd0, 8'h00);
        repeat (3) drive(1'b1, 3'b111, 3'b000, 1'b0, 2'd0, 8'h00);
        drive(1'b1, 3'b111, 3'b000, 1'b1, 2'd0, 8'h80);
        repeat (2) drive(1'b1, 3'b111, 3'b000, 1'b0, 2'd0, 8'h00);
        repeat (3) drive(1'b0, 3'b111, 3'b000, 1'b0, 2'd0, 8'h00);

        repeat (600)
            drive($urandom_range(0, 5) == 0, 3'($urandom), 3'($urandom),
                  $urandom_range(0, 3) == 0, 2'($urandom), 8'($urandom));

        // Asynchronous reset mid-count with a load pending.
        halt   = 1'b0;
        en     = 3'b111;
        ld_vld = 1'b1;
        ld_ch  = 2'd1;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk_reset("async");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (4) drive(1'b0, 3'b111, 3'b101, 1'b1, 2'd1, 8'h33);
        repeat (20)
            drive(1'b0, 3'($urandom), 3'($urandom), $urandom_range(0, 2) == 0,
                  2'($urandom), 8'($urandom));

        repeat (2) @(posedge clk);
        #2;
        chk("queue drained", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/svi_chan_array.md
# svi_chan_array

Parametrised bank of `NUM_CH` independent channel cells. Each cell holds three registers, `x`, `y` and `z`, updated in an `always_ff` block. `x` is an up/down counter, `y` is a rotate register advanced on each counter wrap, and `z` is a saturating wrap count. A shared load port with a valid/ready handshake writes the counters, and a small top-level FSM gates all channels. The block generalises the fixed 8-bit, constant-driven interface-array top into a configurable, stateful channel array used as a synthesis and emulation regression block.

## Interface
- `NUM_CH`, default 3: number of channel cells, 1..16.
- `WIDTH`, default 8: register width per channel, 2..32.
- `CH_W`, default `$clog2(NUM_CH)` with a minimum of 1: load-select width. Derived; not overridden.

- `i_clk` in 1: single clock; all state on the rising edge.
- `i_rst` in 1: reset, asynchronous, active-high.
- `i_halt` in 1: pause all channels while high.
- `i_en` in `NUM_CH`: per-channel step enable.
- `i_dir` in `NUM_CH`: per-channel direction; 0 = up, 1 = down.
- `i_ld_vld` in 1: load request valid.
- `i_ld_ch` in `CH_W`: target channel for the load.
- `i_ld_val` in `WIDTH`: load value.
- `o_ld_rdy` out 1: load port ready.
- `o_ld_err` out 1: one-cycle pulse when an accepted load targets a channel ≥ `NUM_CH`.
- `o_a` out `NUM_CH*WIDTH`: concatenated `x`; channel k occupies bits [k*WIDTH +: WIDTH].
- `o_b` out `NUM_CH*WIDTH`: concatenated `y`, same packing.
- `o_c` out `NUM_CH*WIDTH`: concatenated `z`, same packing.

## Operation
- FSM states: RESET, INIT, RUN, PAUSE.
  - RESET is held while `i_rst` is high.
  - RESET → INIT on the first clock after reset release.
  - INIT → RUN unconditionally after one cycle.
  - RUN → PAUSE when `i_halt` is high; PAUSE → RUN when `i_halt` is low.
- Reset values, for every channel:
  - `x` = 0, `y` = 1 (LSB set), `z` = 0.
  - `o_ld_rdy` = 0, `o_ld_err` = 0.
- In INIT, all registers are rewritten to their reset values and `o_ld_rdy` = 0.
- `o_ld_rdy` = 1 in RUN and PAUSE. A load is accepted when `i_ld_vld` and `o_ld_rdy` are both high.
- Load of channel k = `i_ld_ch`, when k < `NUM_CH`:
  - `x` ← `i_ld_val`, `z` ← 0, `y` unchanged.
  - Allowed in PAUSE.
  - Takes priority over a step on the same channel in the same cycle; other channels step normally.
- Load with `i_ld_ch` ≥ `NUM_CH`: accepted, no register changes, `o_ld_err` = 1 on the next cycle only.
- Step of channel k happens in RUN when `i_en[k]` is high and channel k is not being loaded:
  - Up: `x` ← `x` + 1, modulo 2^WIDTH.
  - Down: `x` ← `x` − 1, modulo 2^WIDTH.
- Wrap:
  - Defined as up from all-ones to 0, or down from 0 to all-ones.
  - On wrap, `y` rotates left by 1 (MSB → LSB).
  - On wrap, `z` increments and saturates at 2^WIDTH − 1; it never wraps.
- In PAUSE, `x`, `y` and `z` hold; only loads modify state.

## Timing
- All outputs are registered. A step or load in cycle n is visible on `o_a`/`o_b`/`o_c` in cycle n+1.
- `o_ld_rdy` rises on the first clock edge after INIT, i.e. the second edge after reset release.
- Asserting `i_rst` mid-operation forces every output to its reset value immediately, without a clock. Any in-flight load is dropped.
- `i_halt` is sampled each cycle; the first held cycle is the one after `i_halt` is seen high.
- Simultaneous wrap and `z` at maximum: `y` still rotates and `z` stays at maximum.

## Structure
- Package `svi_chan_pkg` holds:
  - the `state_e` enum (RESET, INIT, RUN, PAUSE);
  - typedef `chan_regs_t` (`x`, `y`, `z`), with `WIDTH` as a package localparam default;
  - function `rotl1`;
  - reset constants `X_RST`, `Y_RST`, `Z_RST`.
- Sub-module `svi_chan_cell`: one channel with `x`/`y`/`z`, step/load/wrap logic and asynchronous reset. The top instantiates it `NUM_CH` times in a generate loop.
- Top `svi_chan_array` contains the FSM, load decode, the error pulse and output packing.

## Test plan
All scenarios use `NUM_CH`=3 and `WIDTH`=8.

1. Reset → release; check cycle by cycle: `o_ld_rdy` is 0 for 2 edges, then 1; `o_a` = 0, `o_b` = 0x010101, `o_c` = 0 throughout.
2. Load ch1 with 0xFE, then `i_en`=3'b010 up for 3 cycles → ch1 `x` goes 0xFF, 0x00, 0x01; on the wrap cycle ch1 `y` becomes 0x02 and `z` becomes 0x01.
3. Ch0 down from 0 with `i_en[0]`=1 → `x` = 0xFF, `y` = 0x02, `z` = 1. Repeat 256 more wraps → `z` saturates at 0xFF.
4. Load ch2 with 0x10 while `i_en[2]`=1 in the same cycle → `x` = 0x10 next cycle (load wins). Load ch3 → `o_ld_err` pulses once, no state change.
5. Assert `i_halt` during counting → `x` holds. A load in PAUSE updates `x`. Deassert `i_halt` → stepping resumes from the loaded value.
6. Assert `i_rst` mid-count with no clock edge → all outputs return to reset values asynchronously.
